// File: rtl/game_state_monitor.sv
// Watches the game controller's packed state bus on the game tick: tracks the game phase,
// infers game over from a stalled pipe, emits score pulses, keeps high scores and the nearest pipe.
module game_state_monitor #(
    parameter int BIRD_X      = 40,
    parameter int PIPE_W      = 50,
    parameter int STALL_TICKS = 3
) (
    input  logic        clk_100ms,
    input  logic        rst,
    input  logic [1:0]  status,
    input  logic [15:0] score,
    input  logic [15:0] bird_y,
    input  logic [31:0] pipe1,
    input  logic [31:0] pipe2,
    input  logic [31:0] pipe3,
    input  logic [31:0] coin,
    output logic [1:0]  phase,
    output logic        game_over,
    output logic        over_pulse,
    output logic        pass_pulse,
    output logic        coin_pulse,
    output logic [15:0] hi_single,
    output logic [15:0] hi_dual,
    output logic        new_record,
    output logic        near_valid,
    output logic [9:0]  near_x,
    output logic [9:0]  near_top,
    output logic [9:0]  near_bot
);

    localparam logic [1:0] PH_IDLE = 2'b00;
    localparam logic [1:0] PH_PLAY = 2'b01;
    localparam logic [1:0] PH_OVER = 2'b10;

    localparam int SW = $clog2(STALL_TICKS + 1);
    localparam logic [SW-1:0] STALL_LIM  = SW'(STALL_TICKS);
    localparam logic [SW-1:0] STALL_SAT  = {SW{1'b1}};
    localparam logic [SW-1:0] STALL_ZERO = {SW{1'b0}};
    localparam logic [10:0]   BIRD_X_W   = 11'(BIRD_X);
    localparam logic [10:0]   PIPE_W_W   = 11'(PIPE_W);

    logic [1:0]    state_r, state_nxt_s;
    logic [15:0]   score_prev_r;
    logic [9:0]    x_prev_r;
    logic [SW-1:0] stall_cnt_r, stall_nxt_s;
    logic          mode_r;
    logic          game_over_r, over_pulse_r, pass_pulse_r, coin_pulse_r, new_record_r;
    logic [15:0]   hi_single_r, hi_dual_r;
    logic          near_valid_r;
    logic [9:0]    near_x_r, near_top_r, near_bot_r;

    logic          restart_s, same_x_s, stall_hit_s;
    logic [15:0]   delta_s, hi_mode_s;
    logic          over_nxt_s, pass_nxt_s, coin_nxt_s, record_nxt_s;
    logic [15:0]   hi_single_nxt_s, hi_dual_nxt_s;
    logic [31:0]   pipe_s [3];
    logic          found_s;
    logic [9:0]    best_x_s, best_top_s;
    logic [7:0]    best_gap_s;

    // Bird and coin positions plus the pipe pad bits are not needed here.
    logic unused_s;
    assign unused_s = ^{bird_y, coin, pipe1[31:28], pipe2[31:28], pipe3[31:28]};

    assign restart_s   = status[1] ^ status[0];
    assign same_x_s    = (pipe1[19:10] == x_prev_r);
    assign delta_s     = score - score_prev_r;
    assign hi_mode_s   = mode_r ? hi_dual_r : hi_single_r;
    assign stall_hit_s = (stall_nxt_s >= STALL_LIM);
    assign pipe_s[0]   = pipe1;
    assign pipe_s[1]   = pipe2;
    assign pipe_s[2]   = pipe3;

    // Stall counter next value: only counts unchanged pipe1 x while playing.
    always_comb begin
        stall_nxt_s = STALL_ZERO;
        if (state_r == PH_PLAY && !restart_s) begin
            if (same_x_s) begin
                if (stall_cnt_r == STALL_SAT) begin
                    stall_nxt_s = stall_cnt_r;
                end else begin
                    stall_nxt_s = stall_cnt_r + 1'b1;
                end
            end else begin
                stall_nxt_s = STALL_ZERO;
            end
        end else begin
            stall_nxt_s = STALL_ZERO;
        end
    end

    // Phase register.
    always_ff @(posedge clk_100ms or negedge rst) begin
        if (!rst) begin
            state_r <= PH_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next phase; a restart status wins over everything else.
    always_comb begin
        state_nxt_s = state_r;
        if (restart_s) begin
            state_nxt_s = PH_IDLE;
        end else begin
            case (state_r)
                PH_IDLE: state_nxt_s = PH_PLAY;
                PH_PLAY: state_nxt_s = stall_hit_s ? PH_OVER : PH_PLAY;
                PH_OVER: state_nxt_s = PH_OVER;
                default: state_nxt_s = PH_IDLE;
            endcase
        end
    end

    // Next values of the event pulses, record flag and high scores.
    always_comb begin
        over_nxt_s      = (state_r == PH_PLAY) && (state_nxt_s == PH_OVER);
        pass_nxt_s      = 1'b0;
        coin_nxt_s      = 1'b0;
        record_nxt_s    = new_record_r;
        hi_single_nxt_s = hi_single_r;
        hi_dual_nxt_s   = hi_dual_r;
        if (state_r == PH_PLAY && !restart_s) begin
            case (delta_s)
                16'd1:   pass_nxt_s = 1'b1;
                16'd2:   coin_nxt_s = 1'b1;
                16'd3:   begin pass_nxt_s = 1'b1; coin_nxt_s = 1'b1; end
                default: begin pass_nxt_s = 1'b0; coin_nxt_s = 1'b0; end
            endcase
        end else begin
            pass_nxt_s = 1'b0;
            coin_nxt_s = 1'b0;
        end
        if (restart_s) begin
            record_nxt_s = 1'b0;
        end else if (over_nxt_s && (score > hi_mode_s)) begin
            record_nxt_s = 1'b1;
            if (mode_r) begin
                hi_dual_nxt_s = score;
            end else begin
                hi_single_nxt_s = score;
            end
        end else begin
            record_nxt_s = new_record_r;
        end
    end

    // Game bookkeeping and registered status outputs.
    always_ff @(posedge clk_100ms or negedge rst) begin
        if (!rst) begin
            score_prev_r <= 16'd0;
            x_prev_r     <= 10'd0;
            stall_cnt_r  <= STALL_ZERO;
            mode_r       <= 1'b0;
            game_over_r  <= 1'b0;
            over_pulse_r <= 1'b0;
            pass_pulse_r <= 1'b0;
            coin_pulse_r <= 1'b0;
            new_record_r <= 1'b0;
            hi_single_r  <= 16'd0;
            hi_dual_r    <= 16'd0;
        end else begin
            score_prev_r <= score;
            x_prev_r     <= pipe1[19:10];
            stall_cnt_r  <= stall_nxt_s;
            if (state_r == PH_IDLE && state_nxt_s == PH_PLAY) begin
                mode_r <= (status == 2'b11);
            end
            game_over_r  <= (state_nxt_s == PH_OVER);
            over_pulse_r <= over_nxt_s;
            pass_pulse_r <= pass_nxt_s;
            coin_pulse_r <= coin_nxt_s;
            new_record_r <= record_nxt_s;
            hi_single_r  <= hi_single_nxt_s;
            hi_dual_r    <= hi_dual_nxt_s;
        end
    end

    // Nearest pipe not yet behind the bird; strict less-than keeps ties on the lower index.
    always_comb begin
        found_s    = 1'b0;
        best_x_s   = 10'd0;
        best_top_s = 10'd0;
        best_gap_s = 8'd0;
        for (int i = 0; i < 3; i++) begin
            if (({1'b0, pipe_s[i][19:10]} + PIPE_W_W) >= BIRD_X_W) begin
                if (!found_s || (pipe_s[i][19:10] < best_x_s)) begin
                    found_s    = 1'b1;
                    best_x_s   = pipe_s[i][19:10];
                    best_top_s = pipe_s[i][9:0];
                    best_gap_s = pipe_s[i][27:20];
                end
            end
        end
    end

    // Nearest-pipe registers hold their value when no candidate exists.
    always_ff @(posedge clk_100ms or negedge rst) begin
        if (!rst) begin
            near_valid_r <= 1'b0;
            near_x_r     <= 10'd0;
            near_top_r   <= 10'd0;
            near_bot_r   <= 10'd0;
        end else begin
            near_valid_r <= found_s;
            if (found_s) begin
                near_x_r   <= best_x_s;
                near_top_r <= best_top_s;
                near_bot_r <= best_top_s + {2'b00, best_gap_s};
            end
        end
    end

    assign phase      = state_r;
    assign game_over  = game_over_r;
    assign over_pulse = over_pulse_r;
    assign pass_pulse = pass_pulse_r;
    assign coin_pulse = coin_pulse_r;
    assign hi_single  = hi_single_r;
    assign hi_dual    = hi_dual_r;
    assign new_record = new_record_r;
    assign near_valid = near_valid_r;
    assign near_x     = near_x_r;
    assign near_top   = near_top_r;
    assign near_bot   = near_bot_r;

endmodule

// File: tb/tb_game_state_monitor.sv
// Directed bench for game_state_monitor: phase flow, stall-based game over, score pulses,
// high scores and nearest-pipe selection, with hand-computed expectations.
module tb_game_state_monitor;

    logic        clk_100ms;
    logic        rst;
    logic [1:0]  status;
    logic [15:0] score, bird_y;
    logic [31:0] pipe1, pipe2, pipe3, coin;
    logic [1:0]  phase;
    logic        game_over, over_pulse, pass_pulse, coin_pulse, new_record, near_valid;
    logic [15:0] hi_single, hi_dual;
    logic [9:0]  near_x, near_top, near_bot;

    int checks = 0;
    int errors = 0;
    logic [9:0] x1;

    game_state_monitor dut (
        .clk_100ms(clk_100ms), .rst(rst), .status(status), .score(score), .bird_y(bird_y),
        .pipe1(pipe1), .pipe2(pipe2), .pipe3(pipe3), .coin(coin),
        .phase(phase), .game_over(game_over), .over_pulse(over_pulse), .pass_pulse(pass_pulse),
        .coin_pulse(coin_pulse), .hi_single(hi_single), .hi_dual(hi_dual), .new_record(new_record),
        .near_valid(near_valid), .near_x(near_x), .near_top(near_top), .near_bot(near_bot)
    );

    initial clk_100ms = 1'b0;
    always #5 clk_100ms = ~clk_100ms;

    function automatic logic [31:0] mk(input logic [9:0] x, input logic [9:0] top, input logic [7:0] gap);
        return {4'b0000, gap, x, top};
    endfunction

    task automatic step();
        @(posedge clk_100ms);
        #1;
    endtask

    // Pipe1 keeps moving so no stall accumulates.
    task automatic play_tick(input logic [15:0] sc);
        x1 = x1 - 10'd2;
        pipe1 = mk(x1, 10'd100, 8'd80);
        score = sc;
        step();
    endtask

    task automatic freeze_tick(input logic [15:0] sc);
        score = sc;
        step();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (phase !== 2'b00) begin errors++; $display("FAIL rst_phase: got %0d want 0", phase); end
        checks++; if ({game_over, over_pulse, pass_pulse, coin_pulse, new_record} !== 5'b0) begin errors++; $display("FAIL rst_flags: got %b want 00000", {game_over, over_pulse, pass_pulse, coin_pulse, new_record}); end
        checks++; if ({hi_single, hi_dual} !== 32'd0) begin errors++; $display("FAIL rst_hi: got %0d/%0d want 0/0", hi_single, hi_dual); end
        step(); step();
        checks++; if (near_valid !== 1'b0 || phase !== 2'b00) begin errors++; $display("FAIL rst_held: got valid %b phase %0d want 0 0", near_valid, phase); end
        rst = 1'b1;
    endtask

    task automatic test_play_entry();
        status = 2'b01;
        step();
        checks++; if (phase !== 2'b00) begin errors++; $display("FAIL idle_phase: got %0d want 0", phase); end
        checks++; if (near_valid !== 1'b1 || near_x !== 10'd300 || near_bot !== 10'd180) begin errors++; $display("FAIL idle_near: got %b %0d %0d want 1 300 180", near_valid, near_x, near_bot); end
        status = 2'b00;
        for (int i = 0; i < 4; i++) begin
            play_tick(16'd0);
            checks++; if (phase !== 2'b01 || game_over !== 1'b0) begin errors++; $display("FAIL play_entry: got phase %0d over %b want 1 0", phase, game_over); end
        end
    endtask

    task automatic test_game_over();
        x1 = 10'd150; pipe1 = mk(x1, 10'd100, 8'd80); score = 16'd3;
        step();
        checks++; if (pass_pulse !== 1'b1 || coin_pulse !== 1'b1) begin errors++; $display("FAIL delta3: got %b%b want 11", pass_pulse, coin_pulse); end
        freeze_tick(16'd3); freeze_tick(16'd3);
        checks++; if (over_pulse !== 1'b0 || phase !== 2'b01) begin errors++; $display("FAIL early_over: got %b phase %0d want 0 1", over_pulse, phase); end
        freeze_tick(16'd3);
        checks++; if (over_pulse !== 1'b1 || phase !== 2'b10 || game_over !== 1'b1) begin errors++; $display("FAIL over1: got %b %0d %b want 1 2 1", over_pulse, phase, game_over); end
        checks++; if (hi_single !== 16'd3 || new_record !== 1'b1) begin errors++; $display("FAIL hi1: got %0d rec %b want 3 1", hi_single, new_record); end
        status = 2'b01; score = 16'd0;
        step();
        checks++; if (phase !== 2'b00 || new_record !== 1'b0 || game_over !== 1'b0 || hi_single !== 16'd3) begin errors++; $display("FAIL restart1: got %0d %b %b %0d want 0 0 0 3", phase, new_record, game_over, hi_single); end
        status = 2'b00;
        step();
        play_tick(16'd4);
        checks++; if (pass_pulse !== 1'b0 || coin_pulse !== 1'b0) begin errors++; $display("FAIL delta4: got %b%b want 00", pass_pulse, coin_pulse); end
        play_tick(16'd5);
        x1 = 10'd150; pipe1 = mk(x1, 10'd100, 8'd80);
        step();
        freeze_tick(16'd5); freeze_tick(16'd5); freeze_tick(16'd5);
        checks++; if (over_pulse !== 1'b1 || phase !== 2'b10 || hi_single !== 16'd5 || new_record !== 1'b1) begin errors++; $display("FAIL over2: got %b %0d %0d %b want 1 2 5 1", over_pulse, phase, hi_single, new_record); end
        freeze_tick(16'd5);
        checks++; if (over_pulse !== 1'b0 || phase !== 2'b10) begin errors++; $display("FAIL over_once: got %b %0d want 0 2", over_pulse, phase); end
    endtask

    task automatic test_score_events();
        status = 2'b01; score = 16'd0; step();
        status = 2'b00; step();
        play_tick(16'd4);
        play_tick(16'd5);
        checks++; if (pass_pulse !== 1'b1 || coin_pulse !== 1'b0) begin errors++; $display("FAIL pass: got %b%b want 10", pass_pulse, coin_pulse); end
        play_tick(16'd5);
        checks++; if (pass_pulse !== 1'b0) begin errors++; $display("FAIL pass_width: got %b want 0", pass_pulse); end
        play_tick(16'd7);
        checks++; if (pass_pulse !== 1'b0 || coin_pulse !== 1'b1) begin errors++; $display("FAIL coin: got %b%b want 01", pass_pulse, coin_pulse); end
        play_tick(16'd10);
        checks++; if (pass_pulse !== 1'b1 || coin_pulse !== 1'b1) begin errors++; $display("FAIL both: got %b%b want 11", pass_pulse, coin_pulse); end
        status = 2'b01; score = 16'd0;
        step();
        checks++; if ({pass_pulse, coin_pulse, over_pulse} !== 3'b000 || phase !== 2'b00) begin errors++; $display("FAIL restart_nopulse: got %b phase %0d want 000 0", {pass_pulse, coin_pulse, over_pulse}, phase); end
    endtask

    task automatic test_reset_mid_play();
        status = 2'b00; step();
        play_tick(16'd7);
        x1 = 10'd150; pipe1 = mk(x1, 10'd100, 8'd80);
        step();
        freeze_tick(16'd7); freeze_tick(16'd7); freeze_tick(16'd7);
        checks++; if (hi_single !== 16'd7 || phase !== 2'b10) begin errors++; $display("FAIL hi7: got %0d phase %0d want 7 2", hi_single, phase); end
        status = 2'b01; step();
        status = 2'b00; step();
        play_tick(16'd9);
        checks++; if (coin_pulse !== 1'b1 || phase !== 2'b01) begin errors++; $display("FAIL pre_rst: got coin %b phase %0d want 1 1", coin_pulse, phase); end
        rst = 1'b0; status = 2'b01;
        #1;
        checks++; if (phase !== 2'b00 || hi_single !== 16'd0 || {pass_pulse, coin_pulse, over_pulse} !== 3'b000) begin errors++; $display("FAIL async_rst: got %0d %0d %b want 0 0 000", phase, hi_single, {pass_pulse, coin_pulse, over_pulse}); end
        step();
        rst = 1'b1;
    endtask

    task automatic test_nearest();
        pipe1 = mk(10'd20, 10'd60, 8'd90); pipe2 = mk(10'd210, 10'd100, 8'd80); pipe3 = mk(10'd420, 10'd100, 8'd80);
        step();
        checks++; if (near_valid !== 1'b1 || near_x !== 10'd20 || near_top !== 10'd60 || near_bot !== 10'd150) begin errors++; $display("FAIL near20: got %b %0d %0d %0d want 1 20 60 150", near_valid, near_x, near_top, near_bot); end
        pipe1 = mk(10'd630, 10'd60, 8'd90); pipe2 = mk(10'd200, 10'd110, 8'd70); pipe3 = mk(10'd410, 10'd100, 8'd80);
        step();
        checks++; if (near_x !== 10'd200 || near_top !== 10'd110 || near_bot !== 10'd180) begin errors++; $display("FAIL near200: got %0d %0d %0d want 200 110 180", near_x, near_top, near_bot); end
        pipe1 = mk(10'd300, 10'd50, 8'd80); pipe2 = mk(10'd300, 10'd200, 8'd80); pipe3 = mk(10'd500, 10'd100, 8'd80);
        step();
        checks++; if (near_x !== 10'd300 || near_top !== 10'd50) begin errors++; $display("FAIL near_tie: got %0d %0d want 300 50", near_x, near_top); end
        pipe1 = mk(10'd50, 10'd1000, 8'd100); pipe2 = mk(10'd600, 10'd100, 8'd80); pipe3 = mk(10'd700, 10'd100, 8'd80);
        step();
        checks++; if (near_x !== 10'd50 || near_bot !== 10'd76) begin errors++; $display("FAIL near_trunc: got %0d %0d want 50 76", near_x, near_bot); end
    endtask

    task automatic test_dual();
        x1 = 10'd300; pipe1 = mk(x1, 10'd100, 8'd80); pipe2 = mk(10'd400, 10'd100, 8'd80); pipe3 = mk(10'd500, 10'd100, 8'd80);
        status = 2'b01; score = 16'd0; step();
        status = 2'b11; step();
        play_tick(16'd9);
        x1 = 10'd150; pipe1 = mk(x1, 10'd100, 8'd80);
        step();
        freeze_tick(16'd9); freeze_tick(16'd9); freeze_tick(16'd9);
        checks++; if (hi_dual !== 16'd9 || hi_single !== 16'd0 || new_record !== 1'b1 || phase !== 2'b10) begin errors++; $display("FAIL dual_over: got %0d %0d %b %0d want 9 0 1 2", hi_dual, hi_single, new_record, phase); end
        status = 2'b10; score = 16'd0;
        step();
        checks++; if (new_record !== 1'b0 || hi_dual !== 16'd9 || phase !== 2'b00) begin errors++; $display("FAIL dual_restart: got %b %0d %0d want 0 9 0", new_record, hi_dual, phase); end
        status = 2'b11; step();
        play_tick(16'd4);
        x1 = 10'd150; pipe1 = mk(x1, 10'd100, 8'd80);
        step();
        freeze_tick(16'd4); freeze_tick(16'd4); freeze_tick(16'd4);
        checks++; if (new_record !== 1'b0 || hi_dual !== 16'd9 || phase !== 2'b10) begin errors++; $display("FAIL dual_norecord: got %b %0d %0d want 0 9 2", new_record, hi_dual, phase); end
    endtask

    initial begin
        rst = 1'b0; status = 2'b01; score = 16'd0; bird_y = 16'd0; coin = 32'd0;
        x1 = 10'd300;
        pipe1 = mk(x1, 10'd100, 8'd80); pipe2 = mk(10'd400, 10'd100, 8'd80); pipe3 = mk(10'd500, 10'd100, 8'd80);
        test_reset();
        test_play_entry();
        test_game_over();
        test_score_events();
        test_reset_mid_play();
        test_nearest();
        test_dual();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
